// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, memory depth, FSM state and requester ids for the data-memory arbiter
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DMEM_DEPTH = 65536;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic {RQ_CPU, RQ_HOST} rq_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester port (req/we/addr/wdata in, gnt/rdata/rvalid/err out); master = requester, slave = arbiter
interface dmem_arbiter_if;
  import dmem_pkg::*;
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic gnt;
  logic [DATA_W-1:0] rdata;
  logic rvalid;
  logic err;
  modport master (output req, we, addr, wdata, input gnt, rdata, rvalid, err);
  modport slave (input req, we, addr, wdata, output gnt, rdata, rvalid, err);
endinterface

// File: rtl/dmem_clear_seq.sv
// dmem_clear_seq: zero-fill address counter 0..DEPTH-1 (clk, rst_n, en in; ptr = address to clear, done after DEPTH-1 issued)
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr,
  output logic              done
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      done <= 1'b0;
    end else if (en && !done) begin
      done <= ptr == ADDR_W'(DEPTH - 1);
      if (ptr != ADDR_W'(DEPTH - 1)) ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/host data-memory arbiter with registered memory controls and zero-fill (clk, rst_n, cpu/host slave ports, mem_* bus, busy)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int HOST_MAX_WAIT = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     host,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);
  localparam int WW = $clog2(HOST_MAX_WAIT + 1);
  localparam state_t ST_INIT = CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_RUN;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic [ADDR_W-1:0] clr_ptr;
  logic clr_done;
  logic clr_issue;
  logic host_win;
  logic cpu_win;
  logic acc;
  logic sel_we;
  logic in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic p_rd;
  logic p_err;
  rq_t p_id;
  dmem_clear_seq #(.DEPTH(DEPTH)) u_clr (
    .clk,
    .rst_n,
    .en(state == ST_CLEAR),
    .ptr(clr_ptr),
    .done(clr_done)
  );
  always_comb begin
    clr_issue = state == ST_CLEAR && !clr_done;
    host_win = state == ST_RUN && host.req && (!cpu.req || wait_cnt == WW'(HOST_MAX_WAIT));
    cpu_win = state == ST_RUN && cpu.req && !host_win;
    acc = host_win || cpu_win;
    sel_we = host_win ? host.we : cpu.we;
    sel_addr = host_win ? host.addr : cpu.addr;
    sel_wdata = host_win ? host.wdata : cpu.wdata;
    in_range = sel_addr < ADDR_W'(DEPTH);
  end
  assign cpu.gnt = cpu_win;
  assign host.gnt = host_win;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      busy <= 1'b0;
      wait_cnt <= '0;
      mem_read_address <= '0;
      mem_write_address <= '0;
      mem_write_enable <= 1'b0;
      mem_data_in <= '0;
      p_rd <= 1'b0;
      p_err <= 1'b0;
      p_id <= RQ_CPU;
      cpu.rdata <= '0;
      cpu.rvalid <= 1'b0;
      cpu.err <= 1'b0;
      host.rdata <= '0;
      host.rvalid <= 1'b0;
      host.err <= 1'b0;
    end else begin
      if (state == ST_CLEAR && clr_done) state <= ST_RUN;
      busy <= clr_issue;
      wait_cnt <= (!host.req || host_win) ? '0 : (wait_cnt == WW'(HOST_MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1);
      mem_write_enable <= clr_issue || (acc && sel_we && in_range);
      if (clr_issue) begin
        mem_write_address <= clr_ptr;
        mem_data_in <= '0;
      end else if (acc && sel_we) begin
        mem_write_address <= sel_addr;
        mem_data_in <= sel_wdata;
      end
      if (acc && !sel_we) mem_read_address <= sel_addr;
      p_rd <= acc && !sel_we;
      p_err <= acc && !in_range;
      p_id <= host_win ? RQ_HOST : RQ_CPU;
      cpu.rvalid <= p_rd && p_id == RQ_CPU;
      cpu.err <= p_err && p_id == RQ_CPU;
      if (p_rd && p_id == RQ_CPU) cpu.rdata <= p_err ? '0 : mem_data_out;
      host.rvalid <= p_rd && p_id == RQ_HOST;
      host.err <= p_err && p_id == RQ_HOST;
      if (p_rd && p_id == RQ_HOST) host.rdata <= p_err ? '0 : mem_data_out;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter (DEPTH=16, HOST_MAX_WAIT=8, zero-fill on)
module tb_dmem_arbiter;
  typedef struct {
    logic rd;
    logic [31:0] data;
    logic err;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fill = 1'b1;
  logic [31:0] mra, mwa, mdi, mdo;
  logic mwe, busy;
  logic [31:0] mem [16];
  int tests = 0, fails = 0, cyc = 0, bad_we = 0, w;
  exp_t q[2][$];
  dmem_arbiter_if cpu();
  dmem_arbiter_if host();
  dmem_arbiter #(.DEPTH(16), .HOST_MAX_WAIT(8), .CLEAR_ON_RESET(1)) dut (
    .clk,
    .rst_n,
    .cpu(cpu),
    .host(host),
    .mem_read_address(mra),
    .mem_write_address(mwa),
    .mem_write_enable(mwe),
    .mem_data_in(mdi),
    .mem_data_out(mdo),
    .busy
  );
  always #5 clk = ~clk;
  assign mdo = (mra < 32'd16) ? mem[mra[3:0]] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A50000 | 32'(i);
    else if (mwe) begin
      if (mwa < 32'd16) mem[mwa[3:0]] <= mdi;
      else bad_we <= bad_we + 1;
    end
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic resp(int id, logic rv, logic er, logic [31:0] d);
    exp_t e;
    if (q[id].size() == 0) begin
      tests++;
      fails++;
      $display("FAIL resp%0d_unexpected: got rvalid=%b err=%b rdata=%h expected no response", id, rv, er, d);
    end else begin
      e = q[id].pop_front();
      chk($sformatf("resp%0d_rvalid", id), 32'(rv), 32'(e.rd));
      chk($sformatf("resp%0d_err", id), 32'(er), 32'(e.err));
      if (e.rd) chk($sformatf("resp%0d_rdata", id), d, e.data);
      chk($sformatf("resp%0d_cycle", id), 32'(cyc), 32'(e.cyc));
    end
  endtask
  always @(negedge clk) begin
    if (cpu.rvalid || cpu.err) resp(0, cpu.rvalid, cpu.err, cpu.rdata);
    if (host.rvalid || host.err) resp(1, host.rvalid, host.err, host.rdata);
  end
  task automatic op(int id, logic we, logic [31:0] a, logic [31:0] d, logic erd, logic [31:0] edata, logic eerr, output int waits);
    exp_t e;
    logic g;
    @(negedge clk);
    if (id == 0) begin
      cpu.req = 1'b1; cpu.we = we; cpu.addr = a; cpu.wdata = d;
    end else begin
      host.req = 1'b1; host.we = we; host.addr = a; host.wdata = d;
    end
    #1;
    waits = 0;
    g = id == 0 ? cpu.gnt : host.gnt;
    while (!g && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
      g = id == 0 ? cpu.gnt : host.gnt;
    end
    if (!g) begin
      tests++;
      fails++;
      $display("FAIL gnt_timeout%0d: got no grant in %0d cycles expected grant", id, waits);
    end else begin
      @(posedge clk);
      #1;
      if (erd || eerr) begin
        e = '{erd, edata, eerr, cyc + 1};
        q[id].push_back(e);
      end
    end
    cpu.req = 1'b0;
    host.req = 1'b0;
  endtask
  task automatic clear_check(string n);
    int cnt = 0, bad = 0;
    logic [31:0] orv = 0;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) begin
        if (!mwe || mwa != 32'(cnt) || mdi != 0 || cpu.gnt) bad++;
        cnt++;
      end else if (cnt > 0) break;
    end
    chk({n, "_busy_cycles"}, 32'(cnt), 32'd16);
    chk({n, "_zero_writes"}, 32'(bad), 32'd0);
    for (int i = 0; i < 16; i++) orv |= mem[i];
    chk({n, "_mem_zero"}, orv, 32'd0);
    #1;
    chk({n, "_gnt_after"}, 32'(cpu.gnt), 32'd1);
    cpu.req = 1'b0;
  endtask
  initial begin
    cpu.req = 0; cpu.we = 0; cpu.addr = 0; cpu.wdata = 0;
    host.req = 0; host.we = 0; host.addr = 0; host.wdata = 0;
    repeat (3) @(negedge clk);
    fill = 1'b0;
    chk("rst_ctrl", {24'd0, mwe, busy, cpu.gnt, host.gnt, cpu.rvalid, cpu.err, host.rvalid, host.err}, 32'd0);
    chk("rst_addr", mra | mwa | mdi, 32'd0);
    chk("rst_rdata", cpu.rdata | host.rdata, 32'd0);
    clear_check("clr1");
    op(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, w);
    op(0, 0, 5, 0, 1, 32'hDEADBEEF, 0, w);
    chk("t2_read_nowait", 32'(w), 32'd0);
    for (int i = 0; i < 4; i++) op(0, 1, 32'(i), 32'h100 + 32'(i), 0, 0, 0, w);
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 32'(i), 0, 1, 32'h100 + 32'(i), 0, w);
      chk($sformatf("t6_nowait%0d", i), 32'(w), 32'd0);
    end
    op(1, 0, 70000, 0, 1, 0, 1, w);
    op(1, 1, 65536, 32'h123, 0, 0, 1, w);
    op(1, 1, 16, 32'h456, 0, 0, 1, w);
    op(1, 0, 5, 0, 1, 32'hDEADBEEF, 0, w);
    @(negedge clk);
    cpu.req = 1; cpu.we = 1; cpu.addr = 1; cpu.wdata = 11;
    host.req = 1; host.we = 1; host.addr = 2; host.wdata = 22;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk($sformatf("t3_gnt%0d", k), {30'd0, cpu.gnt, host.gnt}, k == 9 ? 32'd1 : 32'd2);
    end
    cpu.req = 0;
    host.req = 0;
    op(0, 0, 2, 0, 1, 22, 0, w);
    op(0, 0, 1, 0, 1, 11, 0, w);
    repeat (3) @(negedge clk);
    op(0, 1, 7, 77, 0, 0, 0, w);
    chk("t5_we_before", 32'(mwe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_we_drop", 32'(mwe), 32'd0);
    repeat (2) @(negedge clk);
    clear_check("clr2");
    op(0, 0, 7, 0, 1, 0, 0, w);
    op(0, 0, 5, 0, 1, 0, 0, w);
    repeat (4) @(negedge clk);
    chk("drain_cpu", 32'(q[0].size()), 32'd0);
    chk("drain_host", 32'(q[1].size()), 32'd0);
    chk("oor_no_we", 32'(bad_we), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
